// File: rtl/control_unit.sv
// Hardwired Moore controller for the single-bus Mini SRC datapath.
// Sequences fetch (T0-T2), decodes ir[31:27] and drives the execute steps
// (T3-T7) for each instruction, then returns to fetch or parks in HALT.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        run,
  // Bus-drive strobes
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        PCout,
  output logic        MDRout,
  output logic        INout,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  // Register-load strobes
  output logic        HIin,
  output logic        LOin,
  output logic        PCin,
  output logic        IRin,
  output logic        Zin,
  output logic        Yin,
  output logic        MARin,
  output logic        MDRin,
  output logic        CONin,
  output logic        OUT_Portin,
  output logic        Rin,
  // Register-select strobes
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  // PC, memory and CON control
  output logic        IncPC,
  output logic        Read,
  output logic        read_mem,
  output logic        write_mem,
  output logic        PCSave,
  output logic        CON_RESET,
  // ALU op selects, one-hot or all zero
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT
);

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] op;
  logic [2:0] last;
  logic       unused_ir;

  // Only the opcode field matters here; the rest of IR feeds the datapath.
  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  // Final execute step of each instruction; nop, undefined opcodes and the
  // single-step instructions finish in T3.
  function automatic logic [2:0] last_step(input logic [4:0] o);
    case (o)
      OpLd, OpSt:                       last_step = 3'd7;
      OpMul, OpDiv, OpBr:               last_step = 3'd6;
      OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl,
      OpAddi, OpAndi, OpOri, OpLdi:     last_step = 3'd5;
      OpNeg, OpNot, OpJal:              last_step = 3'd4;
      default:                          last_step = 3'd3;
    endcase
  endfunction

  assign last = last_step(op);

  // Step sequencing: fetch, then execute up to the opcode's final step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:  state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        if (op == OpHalt)     state_d = StHalt;
        else if (last == 3'd3) state_d = StT0;
        else                  state_d = StT4;
      end
      StT4:   state_d = (last == 3'd4) ? StT0 : StT5;
      StT5:   state_d = (last == 3'd5) ? StT0 : StT6;
      StT6:   state_d = (last == 3'd6) ? StT0 : StT7;
      StT7:   state_d = StT0;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  // State register; reset overrides any step, including mid-instruction.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StRst;
    else       state_q <= state_d;
  end

  // Moore decode of every strobe from the current step and opcode.
  always_comb begin
    run = (state_q != StHalt);
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, BAout, Rout} = '0;
    {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin, Rin} = '0;
    {Gra, Grb, Grc} = '0;
    {IncPC, Read, read_mem, write_mem, PCSave, CON_RESET} = '0;
    {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;

    unique case (state_q)
      StRst: CON_RESET = 1'b1;
      StT0: begin
        IncPC = 1'b1;
        MARin = 1'b1;
        PCin  = 1'b1;
      end
      StT1: begin
        Read     = 1'b1;
        read_mem = 1'b1;
        MDRin    = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StHalt: ;
      default: begin
        case (op)
          OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl: begin
            case (state_q)
              StT3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              StT4: begin
                Grc  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                case (op)
                  OpAdd:   ADD  = 1'b1;
                  OpSub:   SUB  = 1'b1;
                  OpAnd:   AND  = 1'b1;
                  OpOr:    OR   = 1'b1;
                  OpRor:   ROR  = 1'b1;
                  OpRol:   ROL  = 1'b1;
                  OpShr:   SHR  = 1'b1;
                  OpShra:  SHRA = 1'b1;
                  OpShl:   SHL  = 1'b1;
                  default: ;
                endcase
              end
              StT5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OpAddi, OpAndi, OpOri: begin
            case (state_q)
              StT3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              StT4: begin
                Cout = 1'b1;
                Zin  = 1'b1;
                ADD  = (op == OpAddi);
                AND  = (op == OpAndi);
                OR   = (op == OpOri);
              end
              StT5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OpMul, OpDiv: begin
            case (state_q)
              StT3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              StT4: begin
                Grb  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                MUL  = (op == OpMul);
                DIV  = (op == OpDiv);
              end
              StT5: begin Zlowout = 1'b1; LOin = 1'b1; end
              StT6: begin Zhighout = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
          end
          OpNeg, OpNot: begin
            case (state_q)
              StT3: begin
                Grb  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                NEG  = (op == OpNeg);
                NOT  = (op == OpNot);
              end
              StT4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          // ld, ldi and st share the effective-address computation in T3-T4.
          OpLd, OpLdi, OpSt: begin
            case (state_q)
              StT3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              StT4: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
              StT5: begin
                Zlowout = 1'b1;
                if (op == OpLdi) begin
                  Gra = 1'b1;
                  Rin = 1'b1;
                end else begin
                  MARin = 1'b1;
                end
              end
              StT6: begin
                if (op == OpLd) begin
                  Read     = 1'b1;
                  read_mem = 1'b1;
                  MDRin    = 1'b1;
                end else begin
                  Gra   = 1'b1;
                  Rout  = 1'b1;
                  MDRin = 1'b1;
                end
              end
              StT7: begin
                if (op == OpLd) begin
                  MDRout = 1'b1;
                  Gra    = 1'b1;
                  Rin    = 1'b1;
                end else begin
                  write_mem = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OpBr: begin
            case (state_q)
              StT3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              StT4: begin PCout = 1'b1; Yin = 1'b1; end
              StT5: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
              // CON FF was loaded at the end of T3, so it is settled here.
              StT6: begin Zlowout = 1'b1; PCin = con_ff; end
              default: ;
            endcase
          end
          OpJr: begin
            if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          end
          OpJal: begin
            case (state_q)
              StT3: PCSave = 1'b1;
              StT4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              default: ;
            endcase
          end
          OpIn: begin
            if (state_q == StT3) begin INout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          OpOut: begin
            if (state_q == StT3) begin Gra = 1'b1; Rout = 1'b1; OUT_Portin = 1'b1; end
          end
          OpMfhi: begin
            if (state_q == StT3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          OpMflo: begin
            if (state_q == StT3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          // nop, halt and undefined opcodes drive nothing in T3.
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed test-plan instructions plus
// randomized instruction streams with random resets, checked every cycle
// against a step-list model of each instruction.
module tb_control_unit;

  typedef logic [43:0] word_t;

  // Bit positions of each strobe in the packed observation word.
  localparam int I_HIOUT = 0,  I_LOOUT = 1,  I_ZHIGHOUT = 2, I_ZLOWOUT = 3, I_PCOUT = 4;
  localparam int I_MDROUT = 5, I_INOUT = 6,  I_COUT = 7,     I_BAOUT = 8,   I_ROUT = 9;
  localparam int I_HIIN = 10,  I_LOIN = 11,  I_PCIN = 12,    I_IRIN = 13,   I_ZIN = 14;
  localparam int I_YIN = 15,   I_MARIN = 16, I_MDRIN = 17,   I_CONIN = 18,  I_OUTPIN = 19;
  localparam int I_RIN = 20,   I_GRA = 21,   I_GRB = 22,     I_GRC = 23,    I_INCPC = 24;
  localparam int I_READ = 25,  I_RDMEM = 26, I_WRMEM = 27,   I_PCSAVE = 28, I_CONRST = 29;
  localparam int I_AND = 30,   I_OR = 31,    I_ADD = 32,     I_SUB = 33,    I_MUL = 34;
  localparam int I_DIV = 35,   I_SHR = 36,   I_SHRA = 37,    I_SHL = 38,    I_ROR = 39;
  localparam int I_ROL = 40,   I_NEG = 41,   I_NOT = 42,     I_RUN = 43;

  localparam logic [4:0] OpLd = 5'd0, OpSt = 5'd2, OpAndi = 5'd13, OpMul = 5'd16;
  localparam logic [4:0] OpBr = 5'd19, OpNop = 5'd26, OpHalt = 5'd27;

  typedef struct packed {
    word_t      w;
    word_t      pm;
    word_t      pv;
    logic [1:0] kind;   // 0 instruction step, 1 reset, 2 halted
    logic [4:0] op;
    logic [3:0] step;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ir = '0;
  logic con_ff = 1'b0;
  logic run;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, BAout, Rout;
  logic HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin, Rin;
  logic Gra, Grb, Grc, IncPC, Read, read_mem, write_mem, PCSave, CON_RESET;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;

  word_t dut_w;
  assign dut_w = {run, NOT, NEG, ROL, ROR, SHL, SHRA, SHR, DIV, MUL, SUB, ADD, OR, AND,
                  CON_RESET, PCSave, write_mem, read_mem, Read, IncPC, Grc, Grb, Gra, Rin,
                  OUT_Portin, CONin, MDRin, MARin, Yin, Zin, IRin, PCin, LOin, HIin, Rout,
                  BAout, Cout, INout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout};

  control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .run(run),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
    .MDRout(MDRout), .INout(INout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .Zin(Zin), .Yin(Yin),
    .MARin(MARin), .MDRin(MDRin), .CONin(CONin), .OUT_Portin(OUT_Portin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .read_mem(read_mem),
    .write_mem(write_mem), .PCSave(PCSave), .CON_RESET(CON_RESET),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  int    op_q[$];
  word_t seq_q[$];
  word_t pin_mask[8];
  word_t pin_val[8];
  int    n_tests = 0;
  int    n_fail = 0;

  function automatic word_t bw(input int i);
    return word_t'(1) << i;
  endfunction

  // Fetch-inclusive instruction latency, straight from the timing table.
  function automatic int lat_of(input int op);
    case (op)
      0, 2:          return 8;
      15, 16, 19:    return 7;
      1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14: return 6;
      17, 18, 21:    return 5;
      default:       return 4;
    endcase
  endfunction

  // Expected strobe word for every step of one instruction, T0 first.
  function automatic void build(input logic [4:0] op, input logic cff);
    word_t r;
    word_t alu;
    r = bw(I_RUN);
    seq_q.delete();
    seq_q.push_back(r | bw(I_INCPC) | bw(I_MARIN) | bw(I_PCIN));
    seq_q.push_back(r | bw(I_READ) | bw(I_RDMEM) | bw(I_MDRIN));
    seq_q.push_back(r | bw(I_MDROUT) | bw(I_IRIN));
    case (op)
      3, 4, 5, 6, 7, 8, 9, 10, 11: begin
        case (op)
          3: alu = bw(I_ADD);  4: alu = bw(I_SUB);  5: alu = bw(I_AND);
          6: alu = bw(I_OR);   7: alu = bw(I_ROR);  8: alu = bw(I_ROL);
          9: alu = bw(I_SHR);  10: alu = bw(I_SHRA); default: alu = bw(I_SHL);
        endcase
        seq_q.push_back(r | bw(I_GRB) | bw(I_ROUT) | bw(I_YIN));
        seq_q.push_back(r | bw(I_GRC) | bw(I_ROUT) | alu | bw(I_ZIN));
        seq_q.push_back(r | bw(I_ZLOWOUT) | bw(I_GRA) | bw(I_RIN));
      end
      12, 13, 14: begin
        alu = (op == 12) ? bw(I_ADD) : (op == 13) ? bw(I_AND) : bw(I_OR);
        seq_q.push_back(r | bw(I_GRB) | bw(I_ROUT) | bw(I_YIN));
        seq_q.push_back(r | bw(I_COUT) | alu | bw(I_ZIN));
        seq_q.push_back(r | bw(I_ZLOWOUT) | bw(I_GRA) | bw(I_RIN));
      end
      15, 16: begin
        alu = (op == 16) ? bw(I_MUL) : bw(I_DIV);
        seq_q.push_back(r | bw(I_GRA) | bw(I_ROUT) | bw(I_YIN));
        seq_q.push_back(r | bw(I_GRB) | bw(I_ROUT) | alu | bw(I_ZIN));
        seq_q.push_back(r | bw(I_ZLOWOUT) | bw(I_LOIN));
        seq_q.push_back(r | bw(I_ZHIGHOUT) | bw(I_HIIN));
      end
      17, 18: begin
        alu = (op == 17) ? bw(I_NEG) : bw(I_NOT);
        seq_q.push_back(r | bw(I_GRB) | bw(I_ROUT) | alu | bw(I_ZIN));
        seq_q.push_back(r | bw(I_ZLOWOUT) | bw(I_GRA) | bw(I_RIN));
      end
      0, 1, 2: begin
        seq_q.push_back(r | bw(I_GRB) | bw(I_BAOUT) | bw(I_YIN));
        seq_q.push_back(r | bw(I_COUT) | bw(I_ADD) | bw(I_ZIN));
        if (op == 1) begin
          seq_q.push_back(r | bw(I_ZLOWOUT) | bw(I_GRA) | bw(I_RIN));
        end else begin
          seq_q.push_back(r | bw(I_ZLOWOUT) | bw(I_MARIN));
          if (op == 0) begin
            seq_q.push_back(r | bw(I_READ) | bw(I_RDMEM) | bw(I_MDRIN));
            seq_q.push_back(r | bw(I_MDROUT) | bw(I_GRA) | bw(I_RIN));
          end else begin
            seq_q.push_back(r | bw(I_GRA) | bw(I_ROUT) | bw(I_MDRIN));
            seq_q.push_back(r | bw(I_WRMEM));
          end
        end
      end
      19: begin
        seq_q.push_back(r | bw(I_GRA) | bw(I_ROUT) | bw(I_CONIN));
        seq_q.push_back(r | bw(I_PCOUT) | bw(I_YIN));
        seq_q.push_back(r | bw(I_COUT) | bw(I_ADD) | bw(I_ZIN));
        seq_q.push_back(r | bw(I_ZLOWOUT) | (cff ? bw(I_PCIN) : word_t'(0)));
      end
      20: seq_q.push_back(r | bw(I_GRA) | bw(I_ROUT) | bw(I_PCIN));
      21: begin
        seq_q.push_back(r | bw(I_PCSAVE));
        seq_q.push_back(r | bw(I_GRA) | bw(I_ROUT) | bw(I_PCIN));
      end
      22: seq_q.push_back(r | bw(I_INOUT) | bw(I_GRA) | bw(I_RIN));
      23: seq_q.push_back(r | bw(I_GRA) | bw(I_ROUT) | bw(I_OUTPIN));
      24: seq_q.push_back(r | bw(I_HIOUT) | bw(I_GRA) | bw(I_RIN));
      25: seq_q.push_back(r | bw(I_LOOUT) | bw(I_GRA) | bw(I_RIN));
      default: seq_q.push_back(r);  // nop, halt's T3, undefined opcodes
    endcase
  endfunction

  task automatic push(input word_t w, input word_t pm, input word_t pv, input logic [1:0] kind,
                      input logic [4:0] op, input int step);
    exp_t e;
    e.w = w; e.pm = pm; e.pv = pv; e.kind = kind; e.op = op; e.step = 4'(step);
    exp_q.push_back(e);
  endtask

  task automatic pin(input int step, input word_t m, input word_t v);
    pin_mask[step] = m;
    pin_val[step] = v;
  endtask

  // Runs one instruction for ncyc cycles (<0: to completion), acting as the
  // datapath: IR is loaded at the end of T2, CON FF at the end of T3.
  task automatic do_instr(input logic [4:0] op, input logic cff, input int ncyc);
    int n;
    build(op, cff);
    n = (ncyc < 0) ? seq_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        ir = {op, 27'($urandom)};
        op_q.push_back(int'(op));
      end
      if (op == OpBr && i >= 4) con_ff = cff;
      else con_ff = 1'($urandom);
      push(seq_q[i], pin_mask[i], pin_val[i], 2'd0, op, i);
    end
    for (int i = 0; i < 8; i++) begin
      pin_mask[i] = '0;
      pin_val[i] = '0;
    end
  endtask

  // Asserts reset now; the DUT sits in RST for n cycles, then fetches.
  task automatic apply_reset(input int n);
    word_t m;
    m = bw(I_CONRST) | bw(I_WRMEM) | bw(I_RUN);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      con_ff = 1'($urandom);
      if (i == n - 1) reset = 1'b0;
      push(bw(I_RUN) | bw(I_CONRST), m, bw(I_CONRST) | bw(I_RUN), 2'd1, 5'd0, i);
    end
  endtask

  task automatic halted(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      con_ff = 1'($urandom);
      ir = {ir[31:27], 27'($urandom)};
      push('0, (i == 0) ? ~word_t'(0) : word_t'(0), '0, 2'd2, OpHalt, i);
    end
  endtask

  // Single compare process: model word, literal pins and measured latency.
  int cnt = 0;
  bit lat_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int op;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (dut_w !== e.w) begin
        n_fail++;
        $display("FAIL strobes kind%0d op%02h T%0d: got %h want %h", e.kind, e.op, e.step,
                 dut_w, e.w);
      end
      if (e.pm != '0) begin
        n_tests++;
        if ((dut_w & e.pm) !== e.pv) begin
          n_fail++;
          $display("FAIL pin kind%0d op%02h T%0d: got %h want %h", e.kind, e.op, e.step,
                   dut_w & e.pm, e.pv);
        end
      end
    end
    cnt++;
    if (dut_w[I_CONRST] === 1'b1) begin
      op_q.delete();
      lat_valid = 1'b0;
    end else if (dut_w[I_INCPC] === 1'b1) begin
      if (lat_valid && op_q.size() > 0) begin
        op = op_q.pop_front();
        n_tests++;
        if (cnt != lat_of(op)) begin
          n_fail++;
          $display("FAIL latency op%02h: got %0d cycles want %0d", op, cnt, lat_of(op));
        end
      end
      lat_valid = 1'b1;
      cnt = 0;
    end
  end

  initial begin
    int op;
    int r;
    for (int i = 0; i < 8; i++) begin
      pin_mask[i] = '0;
      pin_val[i] = '0;
    end
    apply_reset(2);

    // andi R2,R3,0x25
    pin(3, bw(I_GRB) | bw(I_ROUT) | bw(I_YIN), bw(I_GRB) | bw(I_ROUT) | bw(I_YIN));
    pin(4, bw(I_COUT) | bw(I_AND) | bw(I_ADD) | bw(I_ZIN), bw(I_COUT) | bw(I_AND) | bw(I_ZIN));
    pin(5, bw(I_ZLOWOUT) | bw(I_GRA) | bw(I_RIN), bw(I_ZLOWOUT) | bw(I_GRA) | bw(I_RIN));
    do_instr(OpAndi, 1'b0, -1);
    // ld R1,0x54(R2)
    pin(5, bw(I_MARIN), bw(I_MARIN));
    pin(6, bw(I_READ) | bw(I_RDMEM) | bw(I_MDRIN), bw(I_READ) | bw(I_RDMEM) | bw(I_MDRIN));
    do_instr(OpLd, 1'b0, -1);
    // mul R3,R1
    pin(5, bw(I_LOIN) | bw(I_HIIN), bw(I_LOIN));
    pin(6, bw(I_LOIN) | bw(I_HIIN), bw(I_HIIN));
    do_instr(OpMul, 1'b0, -1);
    // br, not taken then taken
    pin(6, bw(I_PCIN), '0);
    do_instr(OpBr, 1'b0, -1);
    pin(6, bw(I_PCIN), bw(I_PCIN));
    do_instr(OpBr, 1'b1, -1);
    // st cut off by reset in T5; no write may follow
    do_instr(OpSt, 1'b0, 6);
    apply_reset(1);
    pin(0, bw(I_INCPC) | bw(I_WRMEM), bw(I_INCPC));
    do_instr(OpNop, 1'b0, -1);
    // halt, idle, restart
    do_instr(OpHalt, 1'b0, -1);
    halted(5);
    apply_reset(1);
    pin(0, bw(I_INCPC) | bw(I_RUN), bw(I_INCPC) | bw(I_RUN));
    do_instr(OpNop, 1'b0, -1);

    // Random instruction stream with occasional aborts and halts.
    for (int k = 0; k < 250; k++) begin
      op = int'($urandom_range(0, 31));
      r = int'($urandom_range(0, 15));
      if (op == 27) begin
        do_instr(5'(op), 1'b0, -1);
        halted(int'($urandom_range(1, 4)));
        apply_reset(int'($urandom_range(1, 3)));
      end else if (r == 0) begin
        do_instr(5'(op), 1'($urandom), int'($urandom_range(1, lat_of(op) - 1)));
        apply_reset(int'($urandom_range(1, 3)));
      end else begin
        do_instr(5'(op), 1'($urandom), -1);
      end
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Moore-style controller that sequences the single-bus Mini SRC datapath inside `CPU`, replacing the hand-driven control bench. It owns the T0–T7 step sequence. It performs instruction fetch, then decodes the opcode `ir[31:27]` and drives every datapath control strobe until the instruction completes. It returns to fetch, or halts.

## Interface
No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ir  in  32  IR register contents from `CPU`; only `[31:27]` used
- con_ff  in  1  CON FF output from `CPU`
- run  out  1  high while the controller is not in HALT
- HIout, LOout, Zhighout, Zlowout, PCout, MDRout, INout, Cout, BAout, Rout  out  1 each  bus-drive strobes
- HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin, CONin, OUT_Portin, Rin  out  1 each  register-load strobes
- Gra, Grb, Grc  out  1 each  register-select strobes
- IncPC, Read, read_mem, write_mem, PCSave, CON_RESET  out  1 each  PC, memory and CON control
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  out  1 each  ALU op selects, one-hot or all zero

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT. The state register is clocked.
- All outputs decode combinationally from the state and `ir[31:27]`. Every output not listed for a state is 0.
- RST: CON_RESET=1. Next state is T0.
- T0: IncPC, MARin, PCin.
- T1: Read, read_mem, MDRin.
- T2: MDRout, IRin. Next state is T3.
- Opcodes are given as op value followed by the mnemonic.

Execute steps start at T3. The last listed step is followed by T0.
- 00011 add, 00100 sub, 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, the matching op, Zin.
  - T5: Zlowout, Gra, Rin.
- 01100 addi, 01101 andi, 01110 ori:
  - T3: Grb, Rout, Yin.
  - T4: Cout, ADD/AND/OR, Zin.
  - T5: Zlowout, Gra, Rin.
- 10000 mul, 01111 div:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, MUL/DIV, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
- 10001 neg, 10010 not:
  - T3: Grb, Rout, NEG/NOT, Zin.
  - T4: Zlowout, Gra, Rin.
- 00000 ld:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, read_mem, MDRin.
  - T7: MDRout, Gra, Rin.
- 00001 ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, ADD, Zin.
  - T5: Zlowout, Gra, Rin.
- 00010 st:
  - T3–T5: same as ld.
  - T6: Gra, Rout, MDRin.
  - T7: write_mem.
- 10011 br:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, ADD, Zin.
  - T6: Zlowout, plus PCin only if con_ff=1.
- 10100 jr: T3: Gra, Rout, PCin.
- 10101 jal:
  - T3: PCSave.
  - T4: Gra, Rout, PCin.
- 10110 in: T3: INout, Gra, Rin.
- 10111 out: T3: Gra, Rout, OUT_Portin.
- 11000 mfhi: T3: HIout, Gra, Rin.
- 11001 mflo: T3: LOout, Gra, Rin.
- 11010 nop: T3 asserts nothing and goes to T0.
- 11011 halt: T3 goes to HALT.
- Undefined opcodes 11100–11111 behave as nop.
- HALT: all strobes 0, run=0. It is left only by reset.

## Timing
- reset is sampled on a rising clk edge and forces RST, from any state including mid-instruction. Outputs during RST:
  - CON_RESET=1.
  - All other strobes 0.
  - run=1.
- The first T0 follows the first edge at which reset=0.
- Each state lasts exactly one clk cycle. All register loads happen on the edge ending that state.
- Memory read data is valid at the end of the Read cycle (zero wait states).
- Instruction latency, fetch inclusive:
  - 6 cycles: R-type, immediate, ldi.
  - 7 cycles: mul, div, br.
  - 8 cycles: ld, st.
  - 5 cycles: neg, not, jal.
  - 4 cycles: jr, in, out, mfhi, mflo, nop.
  - halt reaches HALT 4 cycles after T0.
- con_ff is sampled during T6 of br. It was written at the end of T3.
- `ir` is stable from T3 until the next T2 ends. The opcode is not latched separately.
- At most one ALU op select is high in any cycle.
- write_mem and Read are never high in the same cycle.

## Test plan
- Reset, then andi R2,R3,0x25 with R3=0x46:
  - Required sequence: RST, T0, T1, T2, T3 (Grb,Rout,Yin), T4 (Cout,AND,Zin), T5 (Zlowout,Gra,Rin).
  - T0 must follow 6 cycles after the first T0.
  - R2 must read 0x04.
- ld R1,0x54(R2) with mem[0x59]=0x97 and R2=5:
  - MARin must be high in T5.
  - Read, read_mem and MDRin must be high in T6.
  - R1 must read 0x97 after T7.
  - Latency must be 8 cycles.
- mul R3,R1 with 0x80000000×2:
  - LOin must be high in T5 and HIin in T6.
  - LO must read 0x0, HI 0x1.
- br with con_ff=0, then repeated with con_ff=1 (C=0x23):
  - con_ff=0: PCin stays 0 in T6, PC=old+1.
  - con_ff=1: PCin=1 in T6, PC=old+1+0x23.
- Reset asserted during T5 of st:
  - The next cycle must be RST with write_mem=0 and CON_RESET=1.
  - T0 must follow once reset drops, with no memory write.
- halt, then several cycles:
  - run must drop 1 cycle after T3 and all strobes must stay 0.
  - A reset pulse must restart at T0 with run=1.
